// File: rtl/r5fp_dump_writer_if.sv
// Record-in / byte-out handshake bundle for r5fp_dump_writer.
// The slave modport is the writer's view; the master modport is its environment.
interface r5fp_dump_writer_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] in_z;
   logic [7:0]   in_flags;
   logic         out_valid;
   logic         out_ready;
   logic [7:0]   out_data;

   modport master (
      output in_valid, in_a, in_b, in_z, in_flags, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_a, in_b, in_z, in_flags, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/r5fp_dump_writer.sv
// Serializes {a, b, z, flags} records into "DUMP: <a> <b> <z> <flags>\n" ASCII bytes.
// Define R5FP_DUMP_CRLF_EN to terminate each line with 8'h0d 8'h0a instead of 8'h0a.
module r5fp_dump_writer #(
   parameter int EXP_W = 8,
   parameter int SIG_W = 23
) (
   input  logic                     clk,
   input  logic                     reset,
   r5fp_dump_writer_if.slave        bus,
   output logic                     busy,
   output logic [31:0]              rec_count
);
   localparam int W  = EXP_W + SIG_W + 1;
   localparam int HD = (W + 3) / 4;
   localparam int PW = HD * 4;
   localparam int CW = (HD > 6) ? $clog2(HD) : 3;
   localparam logic [47:0] PFX_STR = "DUMP: ";

   typedef enum logic [3:0] {
      S_IDLE, S_PFX, S_FA, S_S1, S_FB, S_S2, S_FZ, S_S3, S_FF, S_CR, S_EOL
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_valid_q;
   logic [7:0]      out_data_q;
   logic [31:0]     rec_count_q;
   logic [PW-1:0]   a_q, b_q, z_q;
   logic [7:0]      flags_q;
   logic            adv;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   // Byte shown while the FSM sits in state s with digit counter c.
   function automatic logic [7:0] byte_of(input state_t s, input logic [CW-1:0] c);
      logic [7:0] b;
      case (s)
         S_PFX:                  b = PFX_STR[8*c +: 8];
         S_FA:                   b = hex(a_q[4*c +: 4]);
         S_FB:                   b = hex(b_q[4*c +: 4]);
         S_FZ:                   b = hex(z_q[4*c +: 4]);
         S_FF:                   b = hex(flags_q[4*c[0] +: 4]);
         S_S1, S_S2, S_S3:       b = 8'h20;
         S_CR:                   b = 8'h0d;
         S_EOL:                  b = 8'h0a;
         default:                b = 8'h00;
      endcase
      return b;
   endfunction

   assign adv = out_valid_q && bus.out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE) begin
         if (bus.in_valid) begin
            state_d = S_PFX;
            cnt_d   = CW'(5);
         end
      end else if (adv) begin
         cnt_d = cnt_q - 1'b1;
         case (state_q)
            S_PFX: if (cnt_q == '0) begin
               state_d = S_FA;
               cnt_d   = CW'(HD - 1);
            end
            S_FA:  if (cnt_q == '0) state_d = S_S1;
            S_S1:  begin state_d = S_FB; cnt_d = CW'(HD - 1); end
            S_FB:  if (cnt_q == '0) state_d = S_S2;
            S_S2:  begin state_d = S_FZ; cnt_d = CW'(HD - 1); end
            S_FZ:  if (cnt_q == '0) state_d = S_S3;
            S_S3:  begin state_d = S_FF; cnt_d = CW'(1); end
`ifdef R5FP_DUMP_CRLF_EN
            S_FF:  if (cnt_q == '0) state_d = S_CR;
`else
            S_FF:  if (cnt_q == '0) state_d = S_EOL;
`endif
            S_CR:  state_d = S_EOL;
            S_EOL: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so a stall keeps out_data frozen.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         rec_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= (state_d != S_IDLE);
         out_data_q  <= (state_d != S_IDLE) ? byte_of(state_d, cnt_d) : 8'h00;
         if (state_q == S_EOL && adv)
            rec_count_q <= rec_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && bus.in_valid) begin
         a_q     <= PW'(bus.in_a);
         b_q     <= PW'(bus.in_b);
         z_q     <= PW'(bus.in_z);
         flags_q <= bus.in_flags;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = (state_q != S_IDLE);
   assign rec_count     = rec_count_q;
endmodule

// File: tb/tb_r5fp_dump_writer.sv
// Directed bench for r5fp_dump_writer: FP32 instance plus an FP16 instance.
module tb_r5fp_dump_writer;
   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        busy, busy16;
   logic [31:0] rec_count, rec_count16;
   int          compared = 0;
   int          mismatched = 0;

   r5fp_dump_writer_if #(.W(32)) bus ();
   r5fp_dump_writer_if #(.W(16)) bus16 ();

   r5fp_dump_writer dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy), .rec_count(rec_count)
   );
   r5fp_dump_writer #(.EXP_W(5), .SIG_W(10)) dut16 (
      .clk(clk), .reset(reset), .bus(bus16), .busy(busy16), .rec_count(rec_count16)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bq_t line(input string body);
      bq_t q;
      q = {};
      for (int i = 0; i < body.len(); i++) q.push_back(body[i]);
`ifdef R5FP_DUMP_CRLF_EN
      q.push_back(8'h0d);
`endif
      q.push_back(8'h0a);
      return q;
   endfunction

   task automatic cmp_line(input string tag, input bq_t got, input bq_t exp);
      int bad;
      int n;
      bad = 0;
      n = (got.size() < exp.size()) ? got.size() : exp.size();
      for (int i = 0; i < n; i++) if (got[i] !== exp[i]) bad++;
      check({tag, "_len"}, got.size(), exp.size());
      check({tag, "_bad_bytes"}, bad, 0);
   endtask

   task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                        input logic [7:0] f, input bit hold);
      int w;
      w = 0;
      bus.in_a = a; bus.in_b = b; bus.in_z = z; bus.in_flags = f;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      check("offer_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      if (!hold) bus.in_valid = 1'b0;
   endtask

   // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1 repeating.
   task automatic drain(input int mode, input int maxc, output bq_t got, output int ncyc,
                        output int unstable, output int bubbles, output logic [31:0] cnt_pre);
      logic [7:0] held;
      bit holding, rdy, done;
      int ph;
      got = {}; ncyc = 0; unstable = 0; bubbles = 0; cnt_pre = rec_count;
      holding = 0; done = 0; ph = 0; held = 8'h00;
      while (!done && ncyc < maxc) begin
         rdy = (mode == 0) || (ph % 4 == 0) || (ph % 4 == 3);
         ph++;
         bus.out_ready = rdy;
         if (holding && bus.out_data !== held) unstable++;
         holding = 0;
         if (!bus.out_valid) bubbles++;
         else if (rdy) begin
            got.push_back(bus.out_data);
            cnt_pre = rec_count;
            if (bus.out_data == 8'h0a) done = 1;
         end else begin
            held = bus.out_data;
            holding = 1;
         end
         ncyc++;
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bq_t         got, exp1, exp2, expb, exp16;
      int          ncyc, unstable, bubbles, bub16;
      logic [31:0] cnt_pre;
      bit          done16;

      exp1 = line("DUMP: 3f800000 40000000 40000000 00");
      exp2 = line("DUMP: 7fc00000 ffffffff 0000abcd 11");
      expb = line("DUMP: 00000001 80000000 deadbeef a5");

      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_z = '0; bus.in_flags = '0;
      bus.out_ready = 1'b0;
      bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_z = '0;
      bus16.in_flags = '0; bus16.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data", bus.out_data, 8'h00);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rec_count", rec_count, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      offer(32'h3f800000, 32'h40000000, 32'h40000000, 8'h00, 1'b0);
      check("cap_first_byte", bus.out_data, 8'h44);
      drain(0, 10, got, ncyc, unstable, bubbles, cnt_pre);
      check("partial_len", got.size(), 10);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_rec_count", rec_count, 32'd0);
      check("midrst_in_ready", bus.in_ready, 1'b1);
      offer(32'h3f800000, 32'h40000000, 32'h40000000, 8'h00, 1'b0);
      drain(0, 200, got, ncyc, unstable, bubbles, cnt_pre);
      cmp_line("after_rst_line", got, exp1);
      check("after_rst_count", rec_count, 32'd1);

      offer(32'h3f800000, 32'h40000000, 32'h40000000, 8'h00, 1'b0);
      drain(0, 200, got, ncyc, unstable, bubbles, cnt_pre);
      cmp_line("fp32_line", got, exp1);
      check("fp32_cycles", ncyc, exp1.size());
      check("fp32_bubbles", bubbles, 0);
      check("fp32_count_before_eol", cnt_pre, 32'd1);
      check("fp32_count", rec_count, 32'd2);
      check("fp32_in_ready_after", bus.in_ready, 1'b1);
      check("fp32_busy_after", busy, 1'b0);

      offer(32'h7fc00000, 32'hffffffff, 32'h0000abcd, 8'h11, 1'b0);
      drain(1, 400, got, ncyc, unstable, bubbles, cnt_pre);
      cmp_line("stall_line", got, exp2);
      check("stall_unstable", unstable, 0);
      check("stall_count", rec_count, 32'd3);

      offer(32'h3f800000, 32'h40000000, 32'h40000000, 8'h00, 1'b1);
      bus.in_a = 32'h00000001; bus.in_b = 32'h80000000; bus.in_z = 32'hdeadbeef;
      bus.in_flags = 8'ha5;
      drain(0, 200, got, ncyc, unstable, bubbles, cnt_pre);
      cmp_line("b2b_first", got, exp1);
      check("b2b_gap_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("b2b_second_busy", busy, 1'b1);
      check("b2b_second_first_byte", bus.out_data, 8'h44);
      drain(0, 200, got, ncyc, unstable, bubbles, cnt_pre);
      cmp_line("b2b_second", got, expb);
      check("b2b_count", rec_count, 32'd5);

      exp16 = line("DUMP: 3c00 c000 c000 01");
      bus16.in_a = 16'h3c00; bus16.in_b = 16'hc000; bus16.in_z = 16'hc000;
      bus16.in_flags = 8'h01; bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      got = {}; bub16 = 0; done16 = 0;
      for (int i = 0; i < 60 && !done16; i++) begin
         if (bus16.out_valid) begin
            got.push_back(bus16.out_data);
            done16 = (bus16.out_data == 8'h0a);
         end else bub16++;
         @(posedge clk); #1;
      end
      cmp_line("fp16_line", got, exp16);
      check("fp16_bubbles", bub16, 0);
      check("fp16_count", rec_count16, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
